gray_sync_rx: RTL and testbench
===============================

# gray_sync_rx

Receiving end of a Gray-coded counter crossing a clock domain. It synchronizes a Gray count produced by a `gray_cnt` instance in another clock domain and decodes it to binary. It checks that every accepted change is a legal single-bit Gray step and reports how far the count advanced. It sits in the consumer domain, for example as the read-side pointer receiver of an async FIFO or an event-count monitor.

## Interface
- `SIZE`, 4, width of the Gray count and all count outputs.
- `SYNC_STAGES`, 2, number of synchronizer flops; legal range 2..4.

- `clk`  in  1  consumer-domain clock.
- `nreset`  in  1  asynchronous, active-low reset.
- `gray_in`  in  SIZE  Gray count from the foreign domain; asynchronous to `clk`.
- `en`  in  1  sample enable; when 0, decoded state holds.
- `clr_err`  in  1  synchronous clear of `err_cnt`.
- `bin_q`  out  SIZE  decoded binary count of last accepted sample.
- `delta`  out  SIZE  binary advance at last update, `(new - old) mod 2^SIZE`.
- `step`  out  1  one-cycle pulse: legal single-bit Gray step accepted.
- `err`  out  1  one-cycle pulse: multi-bit change detected.
- `err_cnt`  out  8  saturating count of `err` events.

## Operation
- Sync chain: `SYNC_STAGES` flops clocked by `clk`, reset to 0, run every cycle regardless of `en`. `gs` = last stage.
- State registers:
  - `g_prev` (SIZE): last accepted Gray value, reset 0.
  - `bin_q`, `delta`, `step`, `err`, `err_cnt`: all registered, all reset to 0.
- Decode: `bin[i] = XOR of gs[SIZE-1:i]`. Purely combinational from `gs`.
- Each cycle with `en`=1, compute `hd = popcount(gs ^ g_prev)`:
  - `hd`=0: hold `g_prev`, `bin_q`, `delta`; `step`=0, `err`=0.
  - `hd`=1: `g_prev`<=`gs`; `bin_q`<=`bin`; `delta`<=`bin - bin_q` mod 2^SIZE; `step`=1, `err`=0.
  - `hd`>=2: resynchronize. Update `g_prev`, `bin_q` and `delta` exactly as for `hd`=1; `step`=0, `err`=1. `err_cnt` increments, saturating at 255.
- With `en`=0: `g_prev`, `bin_q`, `delta` hold; `step`=0, `err`=0. Changes accumulated while disabled are evaluated against the stale `g_prev` on re-enable, so more than one step yields `err`.
- Wrap-around: Gray `100..0` to `000..0` is a legal single-bit step (bin 2^SIZE-1 to 0), giving `delta`=1 and `step`=1.
- A backward legal step (e.g. bin 3 to 2) is accepted with `step`=1 and `delta`=2^SIZE-1.
- `clr_err`=1: `err_cnt`<=0 next cycle. This takes priority over a simultaneous error increment; `err` still pulses.
- `nreset` asserted mid-operation:
  - Clears sync chain and all registers immediately.
  - After release, the first nonzero `gs` is compared with `g_prev`=0.

## Timing
- Latency from a `gray_in` change (setup met) to `bin_q`/`step` update: `SYNC_STAGES`+1 rising edges (3 with default).
- `step` and `err` are single-cycle pulses, never both 1 in the same cycle.
- Back-to-back legal steps on consecutive cycles produce consecutive `step` pulses; no dead cycle.
- `gray_in` must only change by one bit per foreign-domain update. Multi-bit source changes, e.g. a `gray_cnt` parallel load, are reported via `err`, not prevented.
- All outputs are 0 while `nreset`=0 and in the first cycle after release.

## Test plan
- Reset: drive `gray_in`=4'h6 with `nreset`=0 → all outputs 0. Release `nreset` → after 3 cycles `err`=1, `bin_q`=4, `delta`=4, `err_cnt`=1.
- Count-up: `en`=1, `gray_in` = 0,1,3,2,6 each held 4 cycles → `bin_q` = 1,2,3,4. Four `step` pulses, each 3 cycles after its change; `delta`=1; `err` never 1.
- Wrap: from `gray_in`=4'h8 (bin 15), change to 4'h0 → `bin_q`=0, `delta`=1, `step`=1, `err`=0. Then step bin 1 to 0 (Gray 1 to 0) → `delta`=4'hF, `step`=1.
- Multi-bit jump: from 0, change `gray_in` to 4'h5 → `err` pulse, `step`=0, `bin_q`=6, `delta`=6, `err_cnt`+1.
- Enable gating: `en`=0, `gray_in` 0→1→3 (4 cycles each) → no output change. Set `en`=1 → `err`=1, `bin_q`=2, `delta`=2.
- Error counter: force 260 multi-bit jumps → `err_cnt` sticks at 255. Then `clr_err`=1 in the same cycle as an `err` pulse → `err_cnt`=0 next cycle.

Source files
------------

// File: rtl/gray_sync_rx.sv
// Consumer-domain receiver for a foreign Gray counter: synchronizes, decodes to binary,
// validates single-bit steps and reports the binary advance per accepted update.
module gray_sync_rx #(
    parameter int unsigned SIZE        = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [SIZE-1:0] gray_in,
    input  logic            en,
    input  logic            clr_err,
    output logic [SIZE-1:0] bin_q,
    output logic [SIZE-1:0] delta,
    output logic            step,
    output logic            err,
    output logic [7:0]      err_cnt
);

    logic [SYNC_STAGES-1:0][SIZE-1:0] sync_q;
    logic [SIZE-1:0]                  gs;
    logic [SIZE-1:0]                  bin;
    logic [SIZE-1:0]                  diff;
    logic                             changed;
    logic                             single;

    logic [SIZE-1:0] g_prev_q, g_prev_d;
    logic [SIZE-1:0] bin_d;
    logic [SIZE-1:0] delta_d;
    logic            step_d;
    logic            err_d;
    logic [7:0]      err_cnt_d;

    // Synchronizer runs every cycle, independent of en.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};
        end
    end

    assign gs = sync_q[SYNC_STAGES-1];

    always_comb begin
        bin = '0;
        for (int i = 0; i < SIZE; i++) begin
            bin[i] = ^(gs >> i);
        end
    end

    assign diff    = gs ^ g_prev_q;
    assign changed = |diff;
    // Exactly one bit set: clearing the lowest set bit leaves nothing.
    assign single  = changed && ((diff & (diff - SIZE'(1))) == '0);

    always_comb begin
        g_prev_d  = g_prev_q;
        bin_d     = bin_q;
        delta_d   = delta;
        step_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt;

        if (en && changed) begin
            // Multi-bit changes still resynchronize to the observed value.
            g_prev_d = gs;
            bin_d    = bin;
            delta_d  = bin - bin_q;
            step_d   = single;
            err_d    = !single;
        end

        if (clr_err) begin
            err_cnt_d = '0;
        end else if (err_d && (err_cnt != 8'hFF)) begin
            err_cnt_d = err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            g_prev_q <= '0;
            bin_q    <= '0;
            delta    <= '0;
            step     <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            g_prev_q <= g_prev_d;
            bin_q    <= bin_d;
            delta    <= delta_d;
            step     <= step_d;
            err      <= err_d;
            err_cnt  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_gray_sync_rx.sv
// Self-checking bench for gray_sync_rx: table-driven rows plus hand-written multi-cycle
// sequences, with per-cycle expectations queued in a scoreboard.
module tb_gray_sync_rx;

    logic       clk = 1'b0;
    logic       nreset;
    logic [3:0] gray_in;
    logic       en;
    logic       clr_err;
    logic [3:0] bin_q;
    logic [3:0] delta;
    logic       step;
    logic       err;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    gray_sync_rx #(
        .SIZE        (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .nreset  (nreset),
        .gray_in (gray_in),
        .en      (en),
        .clr_err (clr_err),
        .bin_q   (bin_q),
        .delta   (delta),
        .step    (step),
        .err     (err),
        .err_cnt (err_cnt)
    );

    typedef struct {
        logic [3:0] bin;
        logic [3:0] delta;
        logic       step;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    // Inputs held for 4 cycles; outputs update at edge 'lat' of the row.
    typedef struct {
        logic [3:0] gray;
        logic       en;
        int         lat;
        logic [3:0] bin;
        logic [3:0] delta;
        logic       step;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    exp_t       sb[$];
    vec_t       tbl[16];
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] cur_bin;
    logic [3:0] cur_delta;
    logic [7:0] cur_cnt;

    task automatic push(input logic s, input logic e);
        exp_t x;
        x.bin   = cur_bin;
        x.delta = cur_delta;
        x.step  = s;
        x.err   = e;
        x.cnt   = cur_cnt;
        sb.push_back(x);
    endtask

    task automatic compare(input string name);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty at %0t", name, $time);
        end else begin
            e = sb.pop_front();
            if ({bin_q, delta, step, err, err_cnt} !== {e.bin, e.delta, e.step, e.err, e.cnt})
            begin
                n_err++;
                $display("FAIL %s @%0t: got bin_q=%h delta=%h step=%b err=%b err_cnt=%0d, want bin_q=%h delta=%h step=%b err=%b err_cnt=%0d",
                         name, $time, bin_q, delta, step, err, err_cnt,
                         e.bin, e.delta, e.step, e.err, e.cnt);
            end
        end
    endtask

    task automatic cycle(input string name);
        @(posedge clk);
        #1;
        compare(name);
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{4'h6, 1'b1, 3, 4'h4, 4'h4, 1'b0, 1'b1, 8'd1};
        tbl[1]  = '{4'h0, 1'b1, 3, 4'h0, 4'hC, 1'b0, 1'b1, 8'd2};
        tbl[2]  = '{4'h1, 1'b1, 3, 4'h1, 4'h1, 1'b1, 1'b0, 8'd2};
        tbl[3]  = '{4'h3, 1'b1, 3, 4'h2, 4'h1, 1'b1, 1'b0, 8'd2};
        tbl[4]  = '{4'h2, 1'b1, 3, 4'h3, 4'h1, 1'b1, 1'b0, 8'd2};
        tbl[5]  = '{4'h6, 1'b1, 3, 4'h4, 4'h1, 1'b1, 1'b0, 8'd2};
        tbl[6]  = '{4'h8, 1'b1, 3, 4'hF, 4'hB, 1'b0, 1'b1, 8'd3};
        tbl[7]  = '{4'h0, 1'b1, 3, 4'h0, 4'h1, 1'b1, 1'b0, 8'd3};
        tbl[8]  = '{4'h1, 1'b1, 3, 4'h1, 4'h1, 1'b1, 1'b0, 8'd3};
        tbl[9]  = '{4'h0, 1'b1, 3, 4'h0, 4'hF, 1'b1, 1'b0, 8'd3};
        tbl[10] = '{4'h5, 1'b1, 3, 4'h6, 4'h6, 1'b0, 1'b1, 8'd4};
        tbl[11] = '{4'h0, 1'b1, 3, 4'h0, 4'hA, 1'b0, 1'b1, 8'd5};
        tbl[12] = '{4'h0, 1'b0, 3, 4'h0, 4'hA, 1'b0, 1'b0, 8'd5};
        tbl[13] = '{4'h1, 1'b0, 3, 4'h0, 4'hA, 1'b0, 1'b0, 8'd5};
        tbl[14] = '{4'h3, 1'b0, 3, 4'h0, 4'hA, 1'b0, 1'b0, 8'd5};
        tbl[15] = '{4'h3, 1'b1, 1, 4'h2, 4'h2, 1'b0, 1'b1, 8'd6};

        cur_bin   = '0;
        cur_delta = '0;
        cur_cnt   = '0;
        nreset    = 1'b0;
        gray_in   = 4'h6;
        en        = 1'b1;
        clr_err   = 1'b0;

        // Reset held with a nonzero source value.
        @(negedge clk);
        push(1'b0, 1'b0);
        compare("reset_hold");
        for (int k = 0; k < 2; k++) begin
            push(1'b0, 1'b0);
            cycle("reset_hold_cyc");
        end
        nreset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            gray_in = tbl[i].gray;
            en      = tbl[i].en;
            for (int j = 1; j <= 4; j++) begin
                if (j == tbl[i].lat) begin
                    cur_bin   = tbl[i].bin;
                    cur_delta = tbl[i].delta;
                    cur_cnt   = tbl[i].cnt;
                    push(tbl[i].step, tbl[i].err);
                end else begin
                    push(1'b0, 1'b0);
                end
                cycle($sformatf("row%0d_c%0d", i, j));
            end
        end

        // Back-to-back legal steps, one per cycle: bin 2 -> 3,4,5,6.
        begin
            logic [3:0] b2b [4];
            b2b[0] = 4'h2;
            b2b[1] = 4'h6;
            b2b[2] = 4'h7;
            b2b[3] = 4'h5;
            for (int k = 0; k < 7; k++) begin
                if (k < 4) gray_in = b2b[k];
                if (k >= 2 && k < 6) begin
                    cur_bin   = cur_bin + 4'd1;
                    cur_delta = 4'h1;
                    push(1'b1, 1'b0);
                end else begin
                    push(1'b0, 1'b0);
                end
                cycle($sformatf("b2b_c%0d", k));
            end
        end

        // 260 multi-bit jumps alternating Gray 0 / 5 drive err_cnt into saturation.
        for (int k = 0; k < 263; k++) begin
            if (k < 260) gray_in = (k % 2 == 0) ? 4'h0 : 4'h5;
            if (k >= 2 && k < 262) begin
                if ((k - 2) % 2 == 0) begin
                    cur_bin   = 4'h0;
                    cur_delta = 4'hA;
                end else begin
                    cur_bin   = 4'h6;
                    cur_delta = 4'h6;
                end
                if (cur_cnt != 8'hFF) cur_cnt = cur_cnt + 8'd1;
                push(1'b0, 1'b1);
            end else begin
                push(1'b0, 1'b0);
            end
            cycle($sformatf("storm_c%0d", k));
        end

        // clr_err on the same edge that registers an err pulse wins over the increment.
        gray_in = 4'h0;
        push(1'b0, 1'b0);
        cycle("clr_c0");
        push(1'b0, 1'b0);
        cycle("clr_c1");
        clr_err   = 1'b1;
        cur_bin   = 4'h0;
        cur_delta = 4'hA;
        cur_cnt   = 8'd0;
        push(1'b0, 1'b1);
        cycle("clr_c2");
        clr_err = 1'b0;
        push(1'b0, 1'b0);
        cycle("clr_c3");

        // Legal step to bin 1, then asynchronous reset mid-operation.
        gray_in = 4'h1;
        push(1'b0, 1'b0);
        cycle("pre_rst_c0");
        push(1'b0, 1'b0);
        cycle("pre_rst_c1");
        cur_bin   = 4'h1;
        cur_delta = 4'h1;
        push(1'b1, 1'b0);
        cycle("pre_rst_c2");
        gray_in   = 4'h3;
        nreset    = 1'b0;
        cur_bin   = '0;
        cur_delta = '0;
        cur_cnt   = '0;
        #1;
        push(1'b0, 1'b0);
        compare("async_reset");
        push(1'b0, 1'b0);
        cycle("rst_hold");
        nreset = 1'b1;
        push(1'b0, 1'b0);
        cycle("post_rst_c0");
        push(1'b0, 1'b0);
        cycle("post_rst_c1");
        cur_bin   = 4'h2;
        cur_delta = 4'h2;
        cur_cnt   = 8'd1;
        push(1'b0, 1'b1);
        cycle("post_rst_c2");
        push(1'b0, 1'b0);
        cycle("post_rst_c3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
